// File: rtl/cache_miss_controller_if.sv
// Bundle of pipeline, replacement-controller, memory and data-array signals
// for the cache miss controller. The controller uses the slave view; the
// surrounding pipeline/memory environment uses the master view.
interface cache_miss_controller_if #(
   parameter int WORDS = 4,
   parameter int AW    = 32
);
   localparam int WW = $clog2(WORDS);

   // pipeline side
   logic          Req;
   logic          Write;
   logic [AW-1:0] Addr;
   logic [31:0]   WData;
   logic          Stall;

   // replacement controller side
   logic          Hit;
   logic [1:0]    S;
   logic          Init;

   // victim line read-back from the arrays
   logic          VictimDirty;
   logic [AW-1:0] VictimAddr;
   logic [31:0]   VictimData;

   // memory beat port
   logic          MemReady;
   logic [31:0]   MemRData;
   logic          MemReq;
   logic          MemWE;
   logic [AW-1:0] MemAddr;
   logic [31:0]   MemWData;

   // data / tag / dirty array control
   logic          LineWE;
   logic [1:0]    LineWay;
   logic [WW-1:0] LineWord;
   logic [31:0]   LineWData;
   logic          TagWE;
   logic          SetDirty;
   logic          ClrDirty;

   modport master (
      output Req, Write, Addr, WData, Hit, S, VictimDirty, VictimAddr,
             VictimData, MemReady, MemRData,
      input  Stall, Init, MemReq, MemWE, MemAddr, MemWData, LineWE, LineWay,
             LineWord, LineWData, TagWE, SetDirty, ClrDirty
   );

   modport slave (
      input  Req, Write, Addr, WData, Hit, S, VictimDirty, VictimAddr,
             VictimData, MemReady, MemRData,
      output Stall, Init, MemReq, MemWE, MemAddr, MemWData, LineWE, LineWay,
             LineWord, LineWData, TagWE, SetDirty, ClrDirty
   );
endinterface

// File: rtl/cache_miss_controller.sv
// Write-back, write-allocate miss handler for a 4-way set-associative data
// cache. Hits complete combinationally in IDLE; a miss stalls the pipeline,
// writes back a dirty victim, refills the line and strobes Init to commit
// the LRU update.
module cache_miss_controller #(
   parameter int WORDS = 4,
   parameter int AW    = 32
) (
   input logic                    CLK,
   input logic                    Reset,
   cache_miss_controller_if.slave bus
);
   localparam int                WW       = $clog2(WORDS);
   localparam logic [WW-1:0]     LAST     = WW'(WORDS - 1);
   localparam logic [AW-1:0]     OFF_MASK = AW'(WORDS * 4 - 1);

   typedef enum logic [1:0] {IDLE, WB, FILL, UPD} state_t;

   state_t        state;
   logic [WW-1:0] beat;
   logic [1:0]    way_q;
   logic [AW-1:0] addr_q;
   logic [AW-1:0] vaddr_q;

   logic [AW-1:0] beat_off;
   logic [AW-1:0] fill_base;

   assign beat_off  = AW'({beat, 2'b00});
   assign fill_base = addr_q & ~OFF_MASK;

   // Miss sequencing: state, beat counter and the values latched at miss detect.
   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge value of the others, exactly like the flops do.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         state   <= IDLE;
         beat    <= '0;
         way_q   <= '0;
         addr_q  <= '0;
         vaddr_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.Req && !bus.Hit) begin
                  way_q   <= bus.S;
                  addr_q  <= bus.Addr;
                  vaddr_q <= bus.VictimAddr;
                  beat    <= '0;
                  state   <= bus.VictimDirty ? WB : FILL;
               end
            end
            WB: begin
               if (bus.MemReady) begin
                  beat <= beat + WW'(1);  // wraps to 0 after the last beat
                  if (beat == LAST) state <= FILL;
               end
            end
            FILL: begin
               if (bus.MemReady) begin
                  beat <= beat + WW'(1);
                  if (beat == LAST) state <= UPD;
               end
            end
            UPD:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Output decode from the current state and the live inputs.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves one
      // unassigned, which would otherwise infer a latch.
      bus.Stall     = (state != IDLE);
      bus.Init      = 1'b0;
      bus.MemReq    = 1'b0;
      bus.MemWE     = 1'b0;
      bus.MemAddr   = '0;
      bus.MemWData  = '0;
      bus.LineWE    = 1'b0;
      bus.LineWay   = bus.S;
      bus.LineWord  = '0;
      bus.LineWData = '0;
      bus.TagWE     = 1'b0;
      bus.SetDirty  = 1'b0;
      bus.ClrDirty  = 1'b0;

      case (state)
         IDLE: begin
            if (bus.Req) begin
               if (bus.Hit) begin
                  bus.Init = 1'b1;
                  if (bus.Write) begin
                     bus.LineWE    = 1'b1;
                     bus.LineWord  = bus.Addr[WW+1:2];
                     bus.LineWData = bus.WData;
                     bus.SetDirty  = 1'b1;
                  end
               end else begin
                  bus.Stall = 1'b1;
               end
            end
         end
         WB: begin
            // the array read port is steered to the victim word so that
            // VictimData is the word being written back this beat
            bus.MemReq   = 1'b1;
            bus.MemWE    = 1'b1;
            bus.MemAddr  = vaddr_q + beat_off;
            bus.MemWData = bus.VictimData;
            bus.LineWay  = way_q;
            bus.LineWord = beat;
         end
         FILL: begin
            bus.MemReq   = 1'b1;
            bus.MemAddr  = fill_base + beat_off;
            bus.LineWay  = way_q;
            bus.LineWord = beat;
            if (bus.MemReady) begin
               bus.LineWE    = 1'b1;
               bus.LineWData = bus.MemRData;
            end
         end
         UPD: begin
            bus.TagWE    = 1'b1;
            bus.ClrDirty = 1'b1;
            bus.Init     = 1'b1;
            bus.LineWay  = way_q;
         end
         default: ;
      endcase
   end
endmodule
